fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 159 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter feeding a single FIFO write port.
// Four requesters compete for the FIFO; the winner owns a burst of up to
// MAX_BURST writes, stalling while the FIFO is full, then ownership moves on.
// Optional feature macro: FIFO_WR_ARB_STATS_EN adds per-requester saturating
// grant counters (grant_cnt) with a synchronous clear (stats_clr).
module fifo_wr_arbiter #(
    parameter int Data_Width = 8,
    parameter int MAX_BURST  = 4,
    parameter int Cnt_Width  = 16
) (
    input  logic                    wr_clk,
    input  logic                    wr_rstn,
    input  logic [3:0]              req,
    input  logic [4*Data_Width-1:0] req_data,
    input  logic                    full,
`ifdef FIFO_WR_ARB_STATS_EN
    input  logic                    stats_clr,
    output logic [4*Cnt_Width-1:0]  grant_cnt,
`endif
    output logic                    wr_en,
    output logic [Data_Width-1:0]   data_in,
    output logic [3:0]              gnt,
    output logic [1:0]              owner,
    output logic                    busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t      state_r;
    logic [1:0]  owner_r;
    logic [1:0]  last_r;
    logic [4:0]  count_r;

    logic                  wr_en_s;
    logic [Data_Width-1:0] data_s;
    logic [3:0]            gnt_s;

    // Round-robin pick: first set request after last_v, wrapping; last_v itself is lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last_v);
        logic [1:0] pick_v;
        logic [1:0] idx_v;
        pick_v = last_v;
        for (int k = 4; k >= 1; k--) begin
            idx_v = last_v + k[1:0];
            if (req_v[idx_v]) begin
                pick_v = idx_v;
            end else begin
                pick_v = pick_v;
            end
        end
        return pick_v;
    endfunction

    // Write strobe, data and grant follow the owner's request and full in the same cycle.
    always_comb begin
        wr_en_s = 1'b0;
        data_s  = {Data_Width{1'b0}};
        gnt_s   = 4'b0000;
        if ((state_r == ST_BURST) && req[owner_r] && !full) begin
            wr_en_s = 1'b1;
            data_s  = req_data[owner_r*Data_Width +: Data_Width];
            gnt_s   = 4'b0001 << owner_r;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    assign wr_en   = wr_en_s;
    assign data_in = data_s;
    assign gnt     = gnt_s;
    assign owner   = owner_r;
    assign busy    = (state_r != ST_IDLE);

    // Burst state machine: arbitration in IDLE, writes in BURST, waiting out full in STALL.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            state_r <= ST_IDLE;
            owner_r <= 2'd0;
            last_r  <= 2'd3;
            count_r <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        owner_r <= rr_pick(req, last_r);
                        count_r <= 5'd0;
                        state_r <= ST_BURST;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (!req[owner_r]) begin
                        last_r  <= owner_r;
                        state_r <= ST_IDLE;
                    end else if (full) begin
                        state_r <= ST_STALL;
                    end else if (count_r == 5'(MAX_BURST - 1)) begin
                        last_r  <= owner_r;
                        count_r <= 5'd0;
                        state_r <= ST_IDLE;
                    end else begin
                        count_r <= count_r + 5'd1;
                    end
                end
                ST_STALL: begin
                    if (!req[owner_r]) begin
                        last_r  <= owner_r;
                        state_r <= ST_IDLE;
                    end else if (!full) begin
                        state_r <= ST_BURST;
                    end else begin
                        state_r <= ST_STALL;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    count_r <= 5'd0;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [Cnt_Width-1:0] cnt_r [4];

    // Per-requester grant counters: saturate at all-ones, clear has priority over counting.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= {Cnt_Width{1'b0}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (stats_clr) begin
                    cnt_r[i] <= {Cnt_Width{1'b0}};
                end else if (gnt_s[i] && (cnt_r[i] != {Cnt_Width{1'b1}})) begin
                    cnt_r[i] <= cnt_r[i] + Cnt_Width'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Flatten the counters onto the grant_cnt bus, requester i at slice i.
    always_comb begin
        grant_cnt = {(4*Cnt_Width){1'b0}};
        for (int i = 0; i < 4; i++) begin
            grant_cnt[i*Cnt_Width +: Cnt_Width] = cnt_r[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes the expected write
// records; a negedge monitor pops and compares whenever wr_en is seen.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          wr_clk = 1'b0;
    logic          wr_rstn = 1'b0;
    logic [3:0]    req = 4'b0000;
    logic [4*DW-1:0] req_data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    logic          full = 1'b0;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic [3:0]    gnt;
    logic [1:0]    owner;
    logic          busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic          stats_clr = 1'b0;
    logic [4*CW-1:0] grant_cnt;
`endif

    fifo_wr_arbiter #(.Data_Width(DW), .MAX_BURST(4), .Cnt_Width(CW)) dut (
        .wr_clk   (wr_clk),
        .wr_rstn  (wr_rstn),
        .req      (req),
        .req_data (req_data),
        .full     (full),
`ifdef FIFO_WR_ARB_STATS_EN
        .stats_clr(stats_clr),
        .grant_cnt(grant_cnt),
`endif
        .wr_en    (wr_en),
        .data_in  (data_in),
        .gnt      (gnt),
        .owner    (owner),
        .busy     (busy)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic [3:0]    g;
        logic [1:0]    o;
        logic [DW-1:0] d;
    } wr_rec_t;

    wr_rec_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] word_tab [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [1:0] o, input int n);
        wr_rec_t r;
        r.g = 4'b0001 << o;
        r.o = o;
        r.d = word_tab[o];
        for (int i = 0; i < n; i++) sb.push_back(r);
    endtask

    // One cycle: check wr_en/busy mid-cycle, then advance to just after the next edge.
    task automatic cycle(input string nm, input logic exp_we, input logic exp_busy);
        #1;
        chk({nm, "_wr_en"}, {31'd0, wr_en}, {31'd0, exp_we});
        chk({nm, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
        @(posedge wr_clk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({nm, "_gnt"}, {28'd0, gnt}, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_owner"}, {30'd0, owner}, 32'd0);
        chk({nm, "_data"}, {24'd0, data_in}, 32'd0);
    endtask

    task automatic do_reset();
        wr_rstn = 1'b0;
        #1;
        check_zero("reset");
        @(posedge wr_clk);
        #1;
        wr_rstn = 1'b1;
    endtask

    task automatic sb_drained(input string nm);
        chk({nm, "_sb_empty"}, sb.size(), 32'd0);
        sb.delete();
    endtask

    // Monitor: every write must match the next scoreboard record; idle cycles must be quiet.
    always @(negedge wr_clk) begin
        wr_rec_t e;
        if (wr_rstn) begin
            if (wr_en) begin
                chk("write_while_full", {31'd0, full}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got gnt %0h data %0h expected no write", gnt, data_in);
                end else begin
                    e = sb.pop_front();
                    chk("wr_gnt", {28'd0, gnt}, {28'd0, e.g});
                    chk("wr_data", {24'd0, data_in}, {24'd0, e.d});
                    chk("wr_owner", {30'd0, owner}, {30'd0, e.o});
                end
            end else begin
                chk("idle_gnt", {28'd0, gnt}, 32'd0);
                chk("idle_data", {24'd0, data_in}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lone requester 1: one IDLE cycle then 4 writes, repeated.
        do_reset();
        req = 4'b0010;
        expect_wr(2'd1, 8);
        for (int b = 0; b < 2; b++) begin
            cycle("lone_idle", 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) cycle("lone_wr", 1'b1, 1'b1);
        end
        req = 4'b0000;
        cycle("lone_end", 1'b0, 1'b0);
        sb_drained("lone");

        // All requesting: owners 0,1,2,3,0, four writes each.
        do_reset();
        req = 4'b1111;
        for (int b = 0; b < 5; b++) expect_wr(2'(b % 4), 4);
        for (int b = 0; b < 5; b++) begin
            cycle("rr_idle", 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) cycle("rr_wr", 1'b1, 1'b1);
        end
        req = 4'b0000;
        cycle("rr_end", 1'b0, 1'b0);
        sb_drained("rr");

        // Requester 2 stalls on full for 3 cycles after 2 writes, then finishes.
        do_reset();
        req = 4'b0100;
        expect_wr(2'd2, 4);
        cycle("stall_c0", 1'b0, 1'b0);
        cycle("stall_c1", 1'b1, 1'b1);
        cycle("stall_c2", 1'b1, 1'b1);
        full = 1'b1;
        cycle("stall_c3", 1'b0, 1'b1);
        cycle("stall_c4", 1'b0, 1'b1);
        cycle("stall_c5", 1'b0, 1'b1);
        full = 1'b0;
        cycle("stall_c6", 1'b0, 1'b1);
        cycle("stall_c7", 1'b1, 1'b1);
        cycle("stall_c8", 1'b1, 1'b1);
        req = 4'b0000;
        cycle("stall_c9", 1'b0, 1'b0);
        sb_drained("stall");

        // Requester 1 drops after one write; 2 follows; then search resumes at 3.
        do_reset();
        req = 4'b0110;
        expect_wr(2'd1, 1);
        expect_wr(2'd2, 1);
        expect_wr(2'd3, 1);
        cycle("drop_c0", 1'b0, 1'b0);
        cycle("drop_c1", 1'b1, 1'b1);
        req = 4'b0100;
        cycle("drop_c2", 1'b0, 1'b1);
        cycle("drop_c3", 1'b0, 1'b0);
        cycle("drop_c4", 1'b1, 1'b1);
        req = 4'b0000;
        cycle("drop_c5", 1'b0, 1'b1);
        req = 4'b1011;
        cycle("drop_c6", 1'b0, 1'b0);
        cycle("drop_c7", 1'b1, 1'b1);
        req = 4'b0000;
        cycle("drop_c8", 1'b0, 1'b1);
        cycle("drop_c9", 1'b0, 1'b0);
        sb_drained("drop");

        // Reset mid-burst of owner 3: outputs clear at once, fresh 4-write burst after.
        do_reset();
        req = 4'b1000;
        expect_wr(2'd3, 2);
        cycle("mrst_c0", 1'b0, 1'b0);
        cycle("mrst_c1", 1'b1, 1'b1);
        cycle("mrst_c2", 1'b1, 1'b1);
        sb_drained("mrst_pre");
        do_reset();
        expect_wr(2'd3, 4);
        cycle("mrst_r0", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("mrst_wr", 1'b1, 1'b1);
        req = 4'b0000;
        cycle("mrst_end", 1'b0, 1'b0);
        sb_drained("mrst");

`ifdef FIFO_WR_ARB_STATS_EN
        // Ten grants to requester 0, then a one-cycle statistics clear.
        do_reset();
        req = 4'b0001;
        expect_wr(2'd0, 10);
        for (int b = 0; b < 3; b++) begin
            cycle("st_idle", 1'b0, 1'b0);
            for (int i = 0; i < ((b == 2) ? 2 : 4); i++) cycle("st_wr", 1'b1, 1'b1);
        end
        req = 4'b0000;
        #1;
        chk("cnt0_before", {16'd0, grant_cnt[0*CW +: CW]}, 32'd10);
        chk("cnt1_before", {16'd0, grant_cnt[1*CW +: CW]}, 32'd0);
        chk("cnt2_before", {16'd0, grant_cnt[2*CW +: CW]}, 32'd0);
        chk("cnt3_before", {16'd0, grant_cnt[3*CW +: CW]}, 32'd0);
        stats_clr = 1'b1;
        @(posedge wr_clk);
        #1;
        stats_clr = 1'b0;
        chk("cnt0_after", {16'd0, grant_cnt[0*CW +: CW]}, 32'd0);
        sb_drained("stats");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
